// File: rtl/ps2_key_receiver_if.sv
// ps2_key_receiver_if: key bus carrying the two most recent PS/2 scan-code bytes.
//   key        {previous byte, newest byte}
//   key_valid  one-cycle pulse when key is updated
//   frame_err  one-cycle pulse on bad stop bit or mid-frame timeout
//   parity_err one-cycle pulse on parity mismatch (only when parity checking is built in)
// master: the receiver (producer); slave: movement/menu logic (consumer).
interface ps2_key_receiver_if;
   logic [15:0] key;
   logic        key_valid;
   logic        frame_err;
   logic        parity_err;

   modport master (
      output key,
      output key_valid,
      output frame_err,
      output parity_err
   );

   modport slave (
      input key,
      input key_valid,
      input frame_err,
      input parity_err
   );
endinterface

// File: rtl/ps2_key_receiver.sv
// ps2_key_receiver: device-to-host PS/2 frame receiver producing a 16-bit key bus.
// Ports:
//   clk       system clock
//   reset     synchronous, active-high reset
//   ps2_clk   raw PS/2 clock pin (asynchronous)
//   ps2_data  raw PS/2 data pin (asynchronous)
//   bus       key bus (master side): key, key_valid, frame_err, parity_err
// Build option: define PS2_PARITY_CHECK_EN to drop frames with bad odd parity and pulse
// parity_err. Without it the parity bit is captured but ignored and parity_err stays 0.
module ps2_key_receiver #(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ps2_clk,
   input  logic               ps2_data,
   ps2_key_receiver_if.master bus
);

   localparam int unsigned FW = $clog2(FILTER_LEN + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef PS2_PARITY_CHECK_EN
   localparam bit ParityCheck = 1'b1;
`else
   localparam bit ParityCheck = 1'b0;
`endif

   typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

   // Synchronizers and clock filter
   logic          clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
   logic          clk_filt_q, clk_filt_prev_q;
   logic [FW-1:0] filt_cnt_q;
   logic          fall;

   // Frame FSM and outputs
   state_e        state_q;
   logic [2:0]    bit_cnt_q;
   logic [7:0]    shreg_q;
   logic          par_q;
   logic [TW-1:0] tcnt_q;
   logic [15:0]   key_q;
   logic          key_valid_q, frame_err_q, parity_err_q;
   logic          parity_ok;

   assign fall      = clk_filt_prev_q & ~clk_filt_q;
   // Odd parity: data byte XOR parity bit must be 1.
   assign parity_ok = ^{shreg_q, par_q};

   always_ff @(posedge clk) begin
      if (reset) begin
         clk_meta_q      <= 1'b1;
         clk_sync_q      <= 1'b1;
         data_meta_q     <= 1'b1;
         data_sync_q     <= 1'b1;
         clk_filt_q      <= 1'b1;
         clk_filt_prev_q <= 1'b1;
         filt_cnt_q      <= '0;
      end else begin
         clk_meta_q      <= ps2_clk;
         clk_sync_q      <= clk_meta_q;
         data_meta_q     <= ps2_data;
         data_sync_q     <= data_meta_q;
         clk_filt_prev_q <= clk_filt_q;
         // Counts consecutive samples that disagree with the filtered level; any agreeing
         // sample restarts the count, so short glitches never reach the threshold.
         if (clk_sync_q == clk_filt_q) begin
            filt_cnt_q <= '0;
         end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
            clk_filt_q <= clk_sync_q;
            filt_cnt_q <= '0;
         end else begin
            filt_cnt_q <= filt_cnt_q + FW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         bit_cnt_q    <= '0;
         shreg_q      <= '0;
         par_q        <= 1'b0;
         tcnt_q       <= '0;
         key_q        <= '0;
         key_valid_q  <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         key_valid_q  <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         if (state_q == StIdle) begin
            tcnt_q <= '0;
            if (fall && !data_sync_q) begin
               state_q   <= StData;
               bit_cnt_q <= '0;
            end
         end else if (fall) begin
            tcnt_q <= '0;
            unique case (state_q)
               StData: begin
                  shreg_q   <= {data_sync_q, shreg_q[7:1]};
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) state_q <= StParity;
               end
               StParity: begin
                  par_q   <= data_sync_q;
                  state_q <= StStop;
               end
               StStop: begin
                  state_q <= StIdle;
                  if (!data_sync_q) begin
                     frame_err_q <= 1'b1;
                  end else if (parity_ok || !ParityCheck) begin
                     key_q       <= {key_q[7:0], shreg_q};
                     key_valid_q <= 1'b1;
                  end else begin
                     parity_err_q <= 1'b1;
                  end
               end
               default: state_q <= StIdle;
            endcase
         end else if (tcnt_q == TW'(TIMEOUT_CYCLES)) begin
            // Mid-frame stall: drop the partial byte.
            state_q     <= StIdle;
            tcnt_q      <= '0;
            frame_err_q <= 1'b1;
         end else begin
            tcnt_q <= tcnt_q + TW'(1);
         end
      end
   end

   assign bus.key        = key_q;
   assign bus.key_valid  = key_valid_q;
   assign bus.frame_err  = frame_err_q;
   assign bus.parity_err = parity_err_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Scoreboard bench for ps2_key_receiver: stimulus pushes expected events, a monitor pops
// and compares whenever the DUT pulses key_valid, frame_err or parity_err.
module tb_ps2_key_receiver;
   localparam int unsigned FILT = 8;
   localparam int unsigned TMO  = 1000;
   localparam int unsigned HALF = 50;

   logic clk = 1'b0;
   logic reset;
   logic ps2_clk;
   logic ps2_data;

   ps2_key_receiver_if bus ();

   ps2_key_receiver #(
      .FILTER_LEN    (FILT),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .ps2_clk (ps2_clk),
      .ps2_data(ps2_data),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  kind;  // 0 key_valid, 1 frame_err, 2 parity_err
      logic [15:0] key;
   } exp_t;

   exp_t        q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] exp_key = 16'h0000;

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic odd_par(input logic [7:0] b);
      return ~^b;
   endfunction

   task automatic push_valid(input logic [7:0] b);
      exp_t e;
      exp_key = {exp_key[7:0], b};
      e.kind  = 2'd0;
      e.key   = exp_key;
      q.push_back(e);
   endtask

   task automatic push_err(input logic [1:0] kind);
      exp_t e;
      e.kind = kind;
      e.key  = exp_key;
      q.push_back(e);
   endtask

   // Sends the first nbits of {stop, parity, byte, start}; data changes while clock is high.
   task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                             input int nbits, input bit glitch);
      logic [10:0] f;
      f = {stop, par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = f[i];
         if (glitch && i >= 3 && i <= 5) begin
            wait_clks(15);
            ps2_clk = 1'b0;
            wait_clks(3);
            ps2_clk = 1'b1;
            wait_clks(HALF - 18);
         end else begin
            wait_clks(HALF);
         end
         ps2_clk = 1'b0;
         wait_clks(HALF);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      wait_clks(2 * HALF);
   endtask

   task automatic check_key(input string name, input logic [15:0] want);
      n_cmp++;
      if (bus.key !== want) begin
         n_bad++;
         $display("FAIL %s: key got %h want %h", name, bus.key, want);
      end
   endtask

   task automatic check_drained(input string name);
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL %s: %0d expected events outstanding, want 0", name, q.size());
         q.delete();
      end
   endtask

   always @(negedge clk) begin : monitor
      int         np;
      logic [1:0] k;
      exp_t       e;
      np = int'(bus.key_valid) + int'(bus.frame_err) + int'(bus.parity_err);
      k  = bus.frame_err ? 2'd1 : (bus.parity_err ? 2'd2 : 2'd0);
      if (np > 1) begin
         n_cmp++;
         n_bad++;
         $display("FAIL onehot: %0d pulses high together, want at most 1", np);
      end
      if (np >= 1) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected: pulse kind %0d key %h, want no pulse", k, bus.key);
         end else begin
            e = q.pop_front();
            n_cmp++;
            if (k !== e.kind) begin
               n_bad++;
               $display("FAIL kind: got %0d want %0d", k, e.kind);
            end
            n_cmp++;
            if (bus.key !== e.key) begin
               n_bad++;
               $display("FAIL event_key: got %h want %h", bus.key, e.key);
            end
         end
      end
   end

   initial begin
      reset    = 1'b1;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      wait_clks(3);
      reset = 1'b0;
      wait_clks(1000);
      check_key("reset_idle", 16'h0000);

      push_valid(8'h1C);
      send_frame(8'h1C, odd_par(8'h1C), 1'b1, 11, 1'b0);
      push_valid(8'hF0);
      send_frame(8'hF0, odd_par(8'hF0), 1'b1, 11, 1'b0);
      push_valid(8'h1C);
      send_frame(8'h1C, odd_par(8'h1C), 1'b1, 11, 1'b0);
      check_key("release_seq", 16'hF01C);

`ifdef PS2_PARITY_CHECK_EN
      push_err(2'd2);
`else
      push_valid(8'h23);
`endif
      send_frame(8'h23, ~odd_par(8'h23), 1'b1, 11, 1'b0);

      // Start bit plus five data bits, then stall past the timeout.
      push_err(2'd1);
      send_frame(8'h1D, odd_par(8'h1D), 1'b1, 6, 1'b0);
      wait_clks(TMO + 10);

      push_valid(8'h1D);
      send_frame(8'h1D, odd_par(8'h1D), 1'b1, 11, 1'b0);

      push_valid(8'h1B);
      send_frame(8'h1B, odd_par(8'h1B), 1'b1, 11, 1'b1);
      wait_clks(200);
      check_drained("drain_main");

      // Partial frame then reset: no events expected, key back to zero.
      send_frame(8'h55, odd_par(8'h55), 1'b1, 5, 1'b0);
      reset = 1'b1;
      wait_clks(1);
      reset   = 1'b0;
      exp_key = 16'h0000;
      wait_clks(TMO + 200);
      check_key("reset_midframe", 16'h0000);

      push_valid(8'h1C);
      send_frame(8'h1C, odd_par(8'h1C), 1'b1, 11, 1'b0);
      wait_clks(200);
      check_drained("drain_final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
